pc_register: RTL and testbench

Architectural 16-bit program counter register for the outel-8227 datapath. It sits directly downstream of the combinational PC incrementer/decrementer and closes its loop:
- drives the current PC to the address bus and to the incrementer inputs;
- latches the incremented or decremented result back.

It also performs relative-branch addition with 6502-style page-crossing fixup, and byte-wise loads from the internal data bus for jumps, returns and vector fetches.

---
 rtl/pc_register_pkg.sv | 16 +
 rtl/pc_register_branch_offset_adder.sv | 23 ++
 rtl/pc_register.sv | 115 +++++++++++
 tb/tb_pc_register.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/pc_register_pkg.sv
// Shared definitions for the outel-8227 program counter datapath.
package pc_register_pkg;

    // FSM states; PC_FIXUP only exists when PC_PAGE_FIXUP_EN is defined.
    typedef enum logic {
        PC_IDLE  = 1'b0,
        PC_FIXUP = 1'b1
    } pc_state_e;

    localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;

    // One page is the span addressed by PCL alone.
    localparam int unsigned PAGE_SIZE = 256;
    localparam int unsigned PAGE_BITS = $clog2(PAGE_SIZE);

endpackage

// File: rtl/pc_register_branch_offset_adder.sv
// Branch low-byte adder: adds a two's-complement offset to PCL and
// reports whether the result left the current page, and in which direction.
import pc_register_pkg::*;

module branch_offset_adder (
    input  logic [PAGE_BITS-1:0] pcl_i,
    input  logic [PAGE_BITS-1:0] offset_i,
    output logic [PAGE_BITS-1:0] sum_o,
    output logic                 cross_o,
    output logic                 dec_o
);

    logic [PAGE_BITS:0] sum_full;
    logic               offset_neg;

    assign sum_full   = {1'b0, pcl_i} + {1'b0, offset_i};
    assign offset_neg = offset_i[PAGE_BITS-1];
    assign sum_o      = sum_full[PAGE_BITS-1:0];
    // Positive offset with carry, or negative offset without carry, leaves the page.
    assign cross_o    = offset_neg ^ sum_full[PAGE_BITS];
    assign dec_o      = offset_neg;

endmodule

// File: rtl/pc_register.sv
// Architectural 16-bit program counter with byte loads, incrementer step and
// relative branches. Optional macro PC_PAGE_FIXUP_EN: a page-crossing branch
// takes an extra FIXUP cycle to adjust PCH (6502 timing); otherwise PCH is
// corrected in the same cycle and busy is tied low.
import pc_register_pkg::*;

module pc_register #(
    parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       step,
    input  logic [7:0] next_low,
    input  logic [7:0] next_high,
    input  logic       load_low,
    input  logic       load_high,
    input  logic       branch,
    input  logic [7:0] data_bus,
    output logic [7:0] pc_low,
    output logic [7:0] pc_high,
    output logic       busy,
    output logic       page_cross
);

    logic [7:0] pcl_q, pcl_d;
    logic [7:0] pch_q, pch_d;
    logic       page_cross_q, page_cross_d;

    logic [7:0] br_sum;
    logic       br_cross;
    logic       br_dec;

`ifdef PC_PAGE_FIXUP_EN
    pc_state_e  state_q, state_d;
    logic       fix_dec_q, fix_dec_d;
`endif

    branch_offset_adder u_branch_offset_adder (
        .pcl_i    (pcl_q),
        .offset_i (data_bus),
        .sum_o    (br_sum),
        .cross_o  (br_cross),
        .dec_o    (br_dec)
    );

    // Next-state: FIXUP adjust, else load > branch > step > hold.
    always_comb begin
        pcl_d        = pcl_q;
        pch_d        = pch_q;
        page_cross_d = 1'b0;
`ifdef PC_PAGE_FIXUP_EN
        state_d      = state_q;
        fix_dec_d    = fix_dec_q;
        if (state_q == PC_FIXUP) begin
            // All commands are ignored while the high byte is corrected.
            pch_d   = fix_dec_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
            state_d = PC_IDLE;
        end else
`endif
        if (load_low || load_high) begin
            if (load_low) begin
                pcl_d = data_bus;
            end
            if (load_high) begin
                pch_d = data_bus;
            end
        end else if (branch) begin
            pcl_d        = br_sum;
            page_cross_d = br_cross;
            if (br_cross) begin
`ifdef PC_PAGE_FIXUP_EN
                state_d   = PC_FIXUP;
                fix_dec_d = br_dec;
`else
                // PCH +/-1 on a crossing equals the full sign-extended 16-bit add.
                pch_d = br_dec ? (pch_q - 8'd1) : (pch_q + 8'd1);
`endif
            end
        end else if (step) begin
            pcl_d = next_low;
            pch_d = next_high;
        end
    end

    // State registers; reset aborts any pending fixup.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            pcl_q        <= RESET_PC[7:0];
            pch_q        <= RESET_PC[15:8];
            page_cross_q <= 1'b0;
`ifdef PC_PAGE_FIXUP_EN
            state_q      <= PC_IDLE;
            fix_dec_q    <= 1'b0;
`endif
        end else begin
            pcl_q        <= pcl_d;
            pch_q        <= pch_d;
            page_cross_q <= page_cross_d;
`ifdef PC_PAGE_FIXUP_EN
            state_q      <= state_d;
            fix_dec_q    <= fix_dec_d;
`endif
        end
    end

    assign pc_low     = pcl_q;
    assign pc_high    = pch_q;
    assign page_cross = page_cross_q;
`ifdef PC_PAGE_FIXUP_EN
    assign busy       = (state_q == PC_FIXUP);
`else
    assign busy       = 1'b0;
`endif

endmodule

// File: tb/tb_pc_register.sv
// Directed table-driven bench for pc_register; expectations follow the
// PC_PAGE_FIXUP_EN setting of the build.
module tb_pc_register;

    typedef struct {
        string      name;
        logic       ll;
        logic       lh;
        logic       st;
        logic       br;
        logic [7:0] db;
        logic [15:0] nxt;
        logic [15:0] exp_pc;
        logic       exp_busy;
        logic       exp_pcx;
    } vec_t;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        step = 1'b0;
    logic [7:0]  next_low = 8'h00;
    logic [7:0]  next_high = 8'h00;
    logic        load_low = 1'b0;
    logic        load_high = 1'b0;
    logic        branch = 1'b0;
    logic [7:0]  data_bus = 8'h00;
    logic [7:0]  pc_low;
    logic [7:0]  pc_high;
    logic        busy;
    logic        page_cross;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    pc_register #(
        .RESET_PC (16'h0000)
    ) dut (
        .clk        (clk),
        .nrst       (nrst),
        .step       (step),
        .next_low   (next_low),
        .next_high  (next_high),
        .load_low   (load_low),
        .load_high  (load_high),
        .branch     (branch),
        .data_bus   (data_bus),
        .pc_low     (pc_low),
        .pc_high    (pc_high),
        .busy       (busy),
        .page_cross (page_cross)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(string name, logic ll, logic lh, logic st, logic br,
                                logic [7:0] db, logic [15:0] nxt, logic [15:0] exp_pc,
                                logic exp_busy, logic exp_pcx);
        vec_t v;
        v.name = name; v.ll = ll; v.lh = lh; v.st = st; v.br = br; v.db = db;
        v.nxt = nxt; v.exp_pc = exp_pc; v.exp_busy = exp_busy; v.exp_pcx = exp_pcx;
        return v;
    endfunction

    task automatic check(string name, logic [15:0] exp_pc, logic exp_busy, logic exp_pcx);
        n_vec++;
        if ({pc_high, pc_low} !== exp_pc || busy !== exp_busy || page_cross !== exp_pcx) begin
            n_bad++;
            $display("FAIL %s: got pc=%h busy=%b page_cross=%b, want pc=%h busy=%b page_cross=%b",
                     name, {pc_high, pc_low}, busy, page_cross, exp_pc, exp_busy, exp_pcx);
        end
    endtask

    task automatic drive(logic ll, logic lh, logic st, logic br, logic [7:0] db,
                         logic [15:0] nxt);
        load_low = ll; load_high = lh; step = st; branch = br; data_bus = db;
        next_high = nxt[15:8]; next_low = nxt[7:0];
    endtask

    initial begin
        //                 name        ll lh st br db     nxt       pc        busy pcx
        vecs.push_back(mk("step1",     0, 0, 1, 0, 8'h00, 16'h0001, 16'h0001, 0, 0));
        vecs.push_back(mk("step2",     0, 0, 1, 0, 8'h00, 16'h0002, 16'h0002, 0, 0));
        vecs.push_back(mk("step3",     0, 0, 1, 0, 8'h00, 16'h0003, 16'h0003, 0, 0));
        vecs.push_back(mk("load_lo",   1, 0, 0, 0, 8'h34, 16'h0000, 16'h0034, 0, 0));
        vecs.push_back(mk("load_hi_w", 0, 1, 1, 0, 8'h12, 16'h0004, 16'h1234, 0, 0));
        vecs.push_back(mk("hold",      0, 0, 0, 0, 8'h77, 16'hAAAA, 16'h1234, 0, 0));
        vecs.push_back(mk("load_both", 1, 1, 0, 1, 8'hF0, 16'h0000, 16'hF0F0, 0, 0));
        vecs.push_back(mk("ld_12F0",   0, 1, 0, 0, 8'h12, 16'h0000, 16'h12F0, 0, 0));
`ifdef PC_PAGE_FIXUP_EN
        vecs.push_back(mk("br_fwd_c1", 0, 0, 0, 1, 8'h20, 16'h0000, 16'h1210, 1, 1));
        vecs.push_back(mk("fix_ign",   1, 1, 1, 1, 8'h55, 16'h0000, 16'h1310, 0, 0));
`else
        vecs.push_back(mk("br_fwd",    0, 0, 0, 1, 8'h20, 16'h0000, 16'h1310, 0, 1));
`endif
        vecs.push_back(mk("pcx_drop",  0, 0, 0, 0, 8'h00, 16'h0000, 16'h1310, 0, 0));
        vecs.push_back(mk("ld_1305",   1, 0, 0, 0, 8'h05, 16'h0000, 16'h1305, 0, 0));
        vecs.push_back(mk("ld_1205",   0, 1, 0, 0, 8'h12, 16'h0000, 16'h1205, 0, 0));
`ifdef PC_PAGE_FIXUP_EN
        vecs.push_back(mk("br_bwd_c1", 0, 0, 0, 1, 8'hF0, 16'h0000, 16'h12F5, 1, 1));
        vecs.push_back(mk("br_bwd_c2", 0, 0, 0, 0, 8'h00, 16'h0000, 16'h11F5, 0, 0));
`else
        vecs.push_back(mk("br_bwd",    0, 0, 0, 1, 8'hF0, 16'h0000, 16'h11F5, 0, 1));
`endif
        vecs.push_back(mk("ld_11F0",   1, 0, 0, 0, 8'hF0, 16'h0000, 16'h11F0, 0, 0));
        vecs.push_back(mk("ld_FFF0",   0, 1, 0, 0, 8'hFF, 16'h0000, 16'hFFF0, 0, 0));
`ifdef PC_PAGE_FIXUP_EN
        vecs.push_back(mk("wrap_up1",  0, 0, 0, 1, 8'h20, 16'h0000, 16'hFF10, 1, 1));
        vecs.push_back(mk("wrap_up2",  0, 0, 0, 0, 8'h00, 16'h0000, 16'h0010, 0, 0));
`else
        vecs.push_back(mk("wrap_up",   0, 0, 0, 1, 8'h20, 16'h0000, 16'h0010, 0, 1));
`endif
        vecs.push_back(mk("ld_0000",   1, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0));
        vecs.push_back(mk("ld_1200",   0, 1, 0, 0, 8'h12, 16'h0000, 16'h1200, 0, 0));
        vecs.push_back(mk("br_nc_fwd", 0, 0, 0, 1, 8'h10, 16'h0000, 16'h1210, 0, 0));
        vecs.push_back(mk("br_nc_bwd", 0, 0, 1, 1, 8'hF0, 16'h5555, 16'h1200, 0, 0));
        vecs.push_back(mk("ld_0000b",  0, 1, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0));
`ifdef PC_PAGE_FIXUP_EN
        vecs.push_back(mk("wrap_dn1",  0, 0, 0, 1, 8'hFF, 16'h0000, 16'h00FF, 1, 1));
        vecs.push_back(mk("wrap_dn2",  0, 0, 0, 0, 8'h00, 16'h0000, 16'hFFFF, 0, 0));
`else
        vecs.push_back(mk("wrap_dn",   0, 0, 0, 1, 8'hFF, 16'h0000, 16'hFFFF, 0, 1));
`endif

        // Reset state, checked while reset is held and after release.
        repeat (2) @(negedge clk);
        check("rst_held", 16'h0000, 1'b0, 1'b0);
        nrst = 1'b1;
        @(posedge clk); #1;
        check("rst_rel", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].ll, vecs[i].lh, vecs[i].st, vecs[i].br, vecs[i].db, vecs[i].nxt);
            @(posedge clk); #1;
            check(vecs[i].name, vecs[i].exp_pc, vecs[i].exp_busy, vecs[i].exp_pcx);
            @(negedge clk);
        end

        // Reset asserted mid-cycle after a crossing branch, with commands pending.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hF0, 16'h0000);
        @(posedge clk); #1;
`ifdef PC_PAGE_FIXUP_EN
        check("mid_fix", 16'h00F0, 1'b1, 1'b1);
`else
        check("mid_fix", 16'hFFF0, 1'b0, 1'b1);
`endif
        drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 16'h4321);
        #2 nrst = 1'b0;
        #1 check("async_rst", 16'h0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("rst_hold2", 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        nrst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h0001);
        @(posedge clk); #1;
        check("post_rst", 16'h0001, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
